// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch stage: address/data widths,
// reset PC, PC increment, prefetch depth and the fetch entry record that is
// stored in the prefetch FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    localparam int PC_WIDTH        = 16;
    localparam int INST_WIDTH      = 32;
    localparam int IMEM_ADDR_WIDTH = 6;
    localparam int FIFO_DEPTH      = 4;

    localparam logic [PC_WIDTH-1:0] RESET_PC = 16'h0000;
    localparam logic [PC_WIDTH-1:0] PC_INCR  = 16'd4;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the two low PC bits are dropped.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_fetch_fifo
// Small synchronous FIFO holding prefetched instructions.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry
//   pop        : remove the head entry (caller only pops when non-empty)
//   flush      : drop every entry; wins over push and pop
//   head       : head entry (meaningful only when not empty)
//   count      : number of stored entries, 0..DEPTH
//   empty      : count == 0
// -----------------------------------------------------------------------------
module inst_fetch_unit_fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    // The fetch credit rule keeps a response from ever arriving to a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency synchronous
// instruction memory, buffers {pc, inst} in a prefetch FIFO and hands them to
// decode over a valid/ready handshake. Branch/jump redirect flushes everything.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   lock            : fetch enable (0 = no new memory reads)
//   imem_rd_en      : memory read strobe (combinational)
//   imem_addr       : registered word address of the current fetch PC
//   imem_rdata      : read data, valid the cycle after imem_rd_en
//   redirect_valid  : taken branch/jump; flush and restart at redirect_pc
//   redirect_pc     : new fetch target (low two bits ignored)
//   inst_valid/data/pc, inst_ready : instruction output handshake
//
// Handshake: an instruction transfers on a cycle where inst_valid & inst_ready
// are both high; while inst_valid is high and inst_ready low, inst_data and
// inst_pc hold steady. inst_valid never depends on inst_ready.
//
// Build option FETCH_BYPASS_EN: when defined, a response arriving while the
// FIFO is empty is presented combinationally the same cycle (and only pushed
// if not accepted). When undefined, every response goes through the FIFO.
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lock,
    output logic                       imem_rd_en,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0]      imem_rdata,
    input  logic                       redirect_valid,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    output logic                       inst_valid,
    output logic [INST_WIDTH-1:0]      inst_data,
    output logic [PC_WIDTH-1:0]        inst_pc,
    input  logic                       inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] fetch_pc_nxt;
    logic [PC_WIDTH-1:0] tag_pc;
    logic                inflight;
    logic                issue;
    logic                kill;
    logic                resp_valid;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [CW-1:0]       count;
    logic [CW:0]         occupancy;
    fetch_entry_t        resp_entry;
    fetch_entry_t        head_entry;

    // Credit: buffered entries plus the one possibly in flight must leave room.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue      = rst_n & lock & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_rd_en = issue;

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_nxt = align_pc(redirect_pc);
        end else if (issue) begin
            fetch_pc_nxt = fetch_pc + PC_INCR;
        end
    end

    // imem_addr is registered from the next PC so it always equals the word
    // address of fetch_pc in the cycle a read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC[IMEM_ADDR_WIDTH+1:2];
            tag_pc    <= '0;
            inflight  <= 1'b0;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            imem_addr <= fetch_pc_nxt[IMEM_ADDR_WIDTH+1:2];
            inflight  <= issue;
            if (issue) tag_pc <= fetch_pc;
        end
    end

    // A redirect in the response cycle discards the returning word; there is
    // never an issue in a redirect cycle, so nothing older can still arrive.
    assign kill       = redirect_valid;
    assign resp_valid = inflight & ~kill;
    assign resp_entry = '{pc: tag_pc, inst: imem_rdata};

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass     = fifo_empty & resp_valid;
    assign inst_valid = ~fifo_empty | bypass;
    assign push       = resp_valid & ~(bypass & inst_ready);
    assign pop        = ~fifo_empty & inst_ready;

    always_comb begin
        inst_data = '0;
        inst_pc   = '0;
        if (!fifo_empty) begin
            inst_data = head_entry.inst;
            inst_pc   = head_entry.pc;
        end else if (bypass) begin
            inst_data = resp_entry.inst;
            inst_pc   = resp_entry.pc;
        end
    end
`else
    assign inst_valid = ~fifo_empty;
    assign push       = resp_valid;
    assign pop        = inst_valid & inst_ready;

    // Zero the outputs when empty so stale storage is never visible.
    always_comb begin
        inst_data = '0;
        inst_pc   = '0;
        if (!fifo_empty) begin
            inst_data = head_entry.inst;
            inst_pc   = head_entry.pc;
        end
    end
`endif

    inst_fetch_unit_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (resp_entry),
        .head  (head_entry),
        .count (count),
        .empty (fifo_empty)
    );

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the datapath's decode/execute logic.
- Owns the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, tagged with their PC, in a small prefetch FIFO.
- Presents instructions to the consumer over a valid/ready handshake; supports branch/jump redirect with flush.

Parameters:
- PC_WIDTH, 16, width of PC and of redirect/tag addresses.
- INST_WIDTH, 32, instruction word width.
- IMEM_ADDR_WIDTH, 6, instruction memory word-address width (64 words).
- FIFO_DEPTH, 4, prefetch buffer entries (power of 2, ≥2).
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- lock  in  1  fetch enable; 0 inhibits new memory reads.
- imem_rd_en  out  1  instruction memory read strobe.
- imem_addr  out  IMEM_ADDR_WIDTH  word address = fetch_pc[IMEM_ADDR_WIDTH+1:2].
- imem_rdata  in  INST_WIDTH  read data, valid the cycle after imem_rd_en.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  PC_WIDTH  new fetch target.
- inst_valid  out  1  head-of-FIFO instruction available.
- inst_data  out  INST_WIDTH  instruction word.
- inst_pc  out  PC_WIDTH  PC of inst_data.
- inst_ready  in  1  consumer accepts; transfer when inst_valid & inst_ready.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - fetch_pc = RESET_PC; FIFO empty; in-flight flag clear.
  - imem_rd_en = 0, imem_addr = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
- Issue:
  - imem_rd_en = lock & ~redirect_valid & (count + inflight < FIFO_DEPTH).
  - On issue: record tag pc = fetch_pc, set inflight, fetch_pc += 4 (wraps modulo 2^PC_WIDTH).
  - imem_addr is a registered output.
- Response: the cycle after an issue, if the issue was not killed, push {tag_pc, imem_rdata} into the FIFO.
  - The credit rule guarantees no overflow; a push while full is a design error (assertion).
- Output:
  - inst_valid = FIFO non-empty; inst_data/inst_pc come from the head entry.
  - Pop on handshake. Push and pop in the same cycle leave the count unchanged.
  - Outputs hold stable while inst_valid & ~inst_ready.
- Latency: issue at cycle N → data in FIFO, inst_valid visible at N+2. Sustained throughput is 1 instruction/cycle when inst_ready = 1.
- Redirect (highest priority):
  - FIFO cleared (inst_valid = 0 the next cycle).
  - Any in-flight response is discarded via a kill flag.
  - fetch_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00}, so misaligned low bits are dropped.
  - No issue in the redirect cycle; the first issue to the new target is the next cycle if lock = 1.
  - Redirect together with a handshake: the pop completes; all other entries are flushed.
- lock = 0:
  - No new issues; fetch_pc holds.
  - An outstanding response is still captured; FIFO draining continues.
  - Redirect is still honoured.
- Address wrap: fetch_pc 16'h00FC → imem_addr 63; next 16'h0100 → imem_addr 0 (tag 16'h0100).
- Reset mid-operation clears everything immediately, including the in-flight response (no push after reset deassertion).

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a valid response arrives, inst_valid/inst_data/inst_pc are driven combinationally from imem_rdata/tag the same cycle.
  - If inst_ready = 1 the instruction is consumed without a push; otherwise it is pushed.
  - Latency becomes issue N → visible N+1.
- Undefined: all responses go through the FIFO; latency N+2; no combinational imem_rdata→output path.

Decomposition:
- Shared header (global_def.h family): PC_WIDTH, INST_WIDTH, IMEM_ADDR_WIDTH, RESET_PC, PC_INCR (4), and a fetch entry typedef {pc, inst}.
- One sub-module: fetch_fifo.
  - Parameterised sync FIFO with push, pop, flush, count, head data.
  - Async active-low reset.
  - Instantiated once.

Test Plan:
- Reset then lock = 1, inst_ready = 1, imem word k = 32'hA000_0000+k → inst_pc 0,4,8,… with matching data; first inst_valid at cycle 2 after lock; one instruction per cycle thereafter.
- inst_ready = 0 for 10 cycles → exactly 4 issues; FIFO full; imem_rd_en stays 0; data and PC held stable.
- Set inst_ready = 1 afterwards → drain resumes in order, no loss or duplicates.
- Redirect to 16'h0042 with an in-flight read and 3 buffered entries → inst_valid = 0 next cycle; stale data never appears; next issue imem_addr = 16, inst_pc 16'h0040.
- lock toggles 1,0,0,1 → no issue on lock = 0 cycles; the in-flight word is still delivered; PC sequence continues gap-free.
- Start at PC 16'h00F8 via redirect → imem_addr 62, 63, 0, 1 with tags F8, FC, 100, 104.
- Assert rst_n = 0 mid-stream with a full FIFO → all outputs 0 immediately; after release, fetch restarts at RESET_PC.
- With FETCH_BYPASS_EN → first inst_valid at cycle 1 after lock.
